oam_dma_engine: RTL and testbench

- Implements the Game Boy OAM DMA triggered by a CPU write to register FF46.
- Copies 160 bytes from source page {FF46, 8'h00..8'h9F} into OAM offsets 0x00..0x9F.
- Sits directly upstream of the OAM block's CPU-side port. Reads through the memory-map read mux; writes drive OAM addr/wdata/we.
- Asserts busy so the bus arbiter can block CPU access to non-HRAM regions during a transfer.

---
 rtl/oam_dma_engine.sv | 183 ++++++++++++++++++
 tb/tb_oam_dma_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : oam_dma_engine
//  Purpose  : Game Boy OAM DMA. A CPU write to FF46 selects a source page;
//             NUM_BYTES bytes are copied from {page, 8'h00..} into OAM
//             offsets 0x00.. at one byte per CYCLES_PER_BYTE clocks.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   system clock
//    rst_n      in   1   asynchronous active-low reset
//    reg_we     in   1   FF46 write strobe (one cycle)
//    reg_wdata  in   8   source page written to FF46
//    reg_rdata  out  8   last value written to FF46
//    src_addr   out  16  source byte address (valid with src_re)
//    src_re     out  1   source read request, data returns next cycle
//    src_rdata  in   8   source read data (1-cycle latency)
//    oam_addr   out  8   OAM write offset (valid with oam_we)
//    oam_wdata  out  8   OAM write data (valid with oam_we)
//    oam_we     out  1   OAM write enable, one cycle per byte
//    busy       out  1   transfer in progress
//    done       out  1   one-cycle pulse after the transfer ends
// ----------------------------------------------------------------------------
//  Build option
//    OAM_DMA_RESTART_EN : when defined, an FF46 write during a transfer
//                         restarts it from byte 0 with the new page.
// ============================================================================
module oam_dma_engine #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 4,
    parameter int NUM_BYTES       = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_we,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] src_addr,
    output logic        src_re,
    input  logic [7:0]  src_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_XFER   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [7:0] LAST_IDX   = 8'(NUM_BYTES - 1);
    localparam logic [3:0] LAST_PHASE = 4'(CYCLES_PER_BYTE - 1);
    localparam logic [3:0] LAST_DELAY = 4'(START_DELAY - 1);
    // With no start delay the first source read follows the trigger directly.
    localparam logic [1:0] S_START    = (START_DELAY > 0) ? S_DELAY : S_XFER;

    logic [1:0] r_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [3:0] r_phase;
    logic [3:0] r_dcnt;
    logic [7:0] r_reg;
    logic       r_busy;
    logic       r_done;

    logic [1:0] w_state_n;
    logic [7:0] w_page_n;
    logic [7:0] w_idx_n;
    logic [3:0] w_phase_n;
    logic [3:0] w_dcnt_n;
    logic       w_accept;
    logic [7:0] w_eff_page;

    // Echo RAM (E000-FDFF) mirrors C000-DDFF; pages E0..FF are pulled down.
    assign w_eff_page = (r_page >= 8'hE0) ? (r_page - 8'h20) : r_page;

    // A write is taken as a new trigger when no transfer is running; the
    // FINISH cycle counts as not running so back-to-back triggers work.
`ifdef OAM_DMA_RESTART_EN
    assign w_accept = reg_we;
`else
    assign w_accept = reg_we && ((r_state == S_IDLE) || (r_state == S_FINISH));
`endif

    // ------------------------------------------------------------------
    // State register (plus registered busy/done and FF46 readback)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_phase <= 4'h0;
            r_dcnt  <= 4'h0;
            r_reg   <= 8'hFF;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_page  <= w_page_n;
            r_idx   <= w_idx_n;
            r_phase <= w_phase_n;
            r_dcnt  <= w_dcnt_n;
            if (reg_we) begin
                r_reg <= reg_wdata;
            end
            r_busy  <= (w_state_n == S_DELAY) || (w_state_n == S_XFER);
            r_done  <= (w_state_n == S_FINISH);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state;
        w_page_n  = r_page;
        w_idx_n   = r_idx;
        w_phase_n = r_phase;
        w_dcnt_n  = r_dcnt;

        unique case (r_state)
            S_IDLE: begin
                w_state_n = S_IDLE;
            end
            S_DELAY: begin
                if (r_dcnt == LAST_DELAY) begin
                    w_state_n = S_XFER;
                    w_phase_n = 4'h0;
                end else begin
                    w_dcnt_n = r_dcnt + 4'd1;
                end
            end
            S_XFER: begin
                if (r_phase == LAST_PHASE) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_n = S_FINISH;
                    end else begin
                        w_idx_n   = r_idx + 8'd1;
                        w_phase_n = 4'h0;
                    end
                end else begin
                    w_phase_n = r_phase + 4'd1;
                end
            end
            S_FINISH: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Trigger (or restart) overrides whatever the sequencer chose.
        if (w_accept) begin
            w_page_n  = reg_wdata;
            w_idx_n   = 8'h00;
            w_phase_n = 4'h0;
            w_dcnt_n  = 4'h0;
            w_state_n = S_START;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    always_comb begin
        src_re    = (r_state == S_XFER) && (r_phase == 4'd0);
        oam_we    = (r_state == S_XFER) && (r_phase == 4'd1);
        src_addr  = src_re ? {w_eff_page, r_idx} : 16'h0000;
        oam_addr  = oam_we ? r_idx : 8'h00;
        // Read data arrives in phase 1, the same cycle as the OAM write.
        oam_wdata = oam_we ? src_rdata : 8'h00;
        reg_rdata = r_reg;
        busy      = r_busy;
        done      = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_oam_dma_engine
//  Purpose  : Self-checking bench for oam_dma_engine (default instance plus a
//             small START_DELAY=0 / CYCLES_PER_BYTE=2 / NUM_BYTES=4 instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_oam_dma_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (defaults) ----------------
    logic        a_we;
    logic [7:0]  a_wd, a_rd, a_srd, a_oa, a_ow;
    logic [15:0] a_sa;
    logic        a_re, a_oe, a_busy, a_done;

    oam_dma_engine u_a (
        .clk(clk), .rst_n(rst_n), .reg_we(a_we), .reg_wdata(a_wd),
        .reg_rdata(a_rd), .src_addr(a_sa), .src_re(a_re), .src_rdata(a_srd),
        .oam_addr(a_oa), .oam_wdata(a_ow), .oam_we(a_oe),
        .busy(a_busy), .done(a_done)
    );

    // ---------------- DUT B (small configuration) ----------------
    logic        b_we;
    logic [7:0]  b_wd, b_rd, b_srd, b_oa, b_ow;
    logic [15:0] b_sa;
    logic        b_re, b_oe, b_busy, b_done;

    oam_dma_engine #(.CYCLES_PER_BYTE(2), .START_DELAY(0), .NUM_BYTES(4)) u_b (
        .clk(clk), .rst_n(rst_n), .reg_we(b_we), .reg_wdata(b_wd),
        .reg_rdata(b_rd), .src_addr(b_sa), .src_re(b_re), .src_rdata(b_srd),
        .oam_addr(b_oa), .oam_wdata(b_ow), .oam_we(b_oe),
        .busy(b_busy), .done(b_done)
    );

    // Source memory with one-cycle read latency
    logic [7:0] mem [65536];
    always @(posedge clk) begin
        if (a_re) a_srd <= mem[a_sa];
        if (b_re) b_srd <= mem[b_sa];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- observation of DUT A ----------------
    logic [7:0]  oam_a [256];
    logic [15:0] sq_a [$];
    int busy_cnt_a, done_cnt_a, done_cyc_a, first_we_a, falls_a, we_cnt_a;
    logic busy_prev_a = 1'b0;

    always @(negedge clk) begin
        if (a_oe) begin
            oam_a[a_oa] = a_ow;
            we_cnt_a++;
            if (first_we_a < 0) first_we_a = cyc;
        end
        if (a_re) sq_a.push_back(a_sa);
        if (a_busy) busy_cnt_a++;
        if (busy_prev_a && !a_busy) falls_a++;
        busy_prev_a = a_busy;
        if (a_done) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (a_re || a_oe) check("one_strobe_a", 32'(a_re & a_oe), 32'd0);
    end

    // ---------------- observation of DUT B ----------------
    logic [7:0] oam_b [256];
    int dq_b [$];
    int busy_cnt_b, we_cnt_b;

    always @(negedge clk) begin
        if (b_oe) begin
            oam_b[b_oa] = b_ow;
            we_cnt_b++;
        end
        if (b_busy) busy_cnt_b++;
        if (b_done) dq_b.push_back(cyc);
        if (b_re || b_oe) check("one_strobe_b", 32'(b_re & b_oe), 32'd0);
    end

    // ---------------- reference model ----------------
    // Source address of byte i for a given FF46 value: the page selects a
    // 256-byte block; the echo region E000-FFFF reads 0x2000 lower.
    function automatic int src_of(input logic [7:0] pg, input int i);
        int a;
        a = int'(pg) * 256 + i;
        if (a >= 32'hE000) a = a - 32'h2000;
        return a;
    endfunction

    function automatic int oam_errs(input bit sel, input logic [7:0] pg, input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (sel == 1'b0) begin
                if (oam_a[i] !== mem[src_of(pg, i)]) e++;
            end else begin
                if (oam_b[i] !== mem[src_of(pg, i)]) e++;
            end
        end
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clr_a();
        for (int i = 0; i < 256; i++) oam_a[i] = 'x;
        sq_a.delete();
        busy_cnt_a = 0; done_cnt_a = 0; done_cyc_a = -1;
        first_we_a = -1; falls_a = 0; we_cnt_a = 0;
    endtask

    task automatic clr_b();
        for (int i = 0; i < 256; i++) oam_b[i] = 'x;
        dq_b.delete();
        busy_cnt_b = 0; we_cnt_b = 0;
    endtask

    task automatic goto_cyc(input int at);
        while (cyc < at) begin
            @(posedge clk);
            #1;
        end
    endtask

    // FF46 write occupying the cycle numbered 'at'
    task automatic pulse_a(input logic [7:0] v, input int at);
        goto_cyc(at);
        a_wd = v; a_we = 1'b1;
        @(posedge clk); #1;
        a_we = 1'b0;
    endtask

    task automatic pulse_b(input logic [7:0] v, input int at);
        goto_cyc(at);
        b_wd = v; b_we = 1'b1;
        @(posedge clk); #1;
        b_we = 1'b0;
    endtask

    task automatic wait_done_a(input int n, input int bound, input string tag);
        int k = 0;
        while (done_cnt_a < n && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 32'(done_cnt_a >= n), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int n;
        logic [7:0] pg, p1, p2;

        rst_n = 1'b0;
        a_we = 1'b0; a_wd = 8'h00;
        b_we = 1'b0; b_wd = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 160; i++) mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
        clr_a();
        clr_b();

        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_rdata", 32'(a_rd),   32'hFF);
        check("rst_src_addr",  32'(a_sa),   32'h0);
        check("rst_src_re",    32'(a_re),   32'h0);
        check("rst_oam_addr",  32'(a_oa),   32'h0);
        check("rst_oam_wdata", 32'(a_ow),   32'h0);
        check("rst_oam_we",    32'(a_oe),   32'h0);
        check("rst_busy",      32'(a_busy), 32'h0);
        check("rst_done",      32'(a_done), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic copy from page C0
        clr_a();
        t = cyc + 1;
        pulse_a(8'hC0, t);
        wait_done_a(1, 1000, "basic_timeout");
        repeat (3) @(posedge clk); #1;
        check("basic_first_we", 32'(first_we_a - t), 32'd6);
        check("basic_done_cyc", 32'(done_cyc_a - t), 32'd645);
        check("basic_busy_len", 32'(busy_cnt_a),     32'd644);
        check("basic_done_cnt", 32'(done_cnt_a),     32'd1);
        check("basic_we_cnt",   32'(we_cnt_a),       32'd160);
        check("basic_oam",      32'(oam_errs(1'b0, 8'hC0, 160)), 32'd0);
        check("basic_reg_rd",   32'(a_rd),           32'hC0);

        // Echo mirror
        clr_a();
        t = cyc + 1;
        pulse_a(8'hE1, t);
        wait_done_a(1, 1000, "echo_timeout");
        repeat (3) @(posedge clk); #1;
        check("echo_reads",   32'(sq_a.size()), 32'd160);
        check("echo_first",   32'(sq_a[0]),     32'hC100);
        check("echo_last",    32'(sq_a[sq_a.size()-1]), 32'hC19F);
        check("echo_oam",     32'(oam_errs(1'b0, 8'hE1, 160)), 32'd0);
        check("echo_reg_rd",  32'(a_rd),        32'hE1);

        // Random pages
        for (int r = 0; r < 3; r++) begin
            pg = 8'($urandom_range(0, 255));
            clr_a();
            t = cyc + 1 + int'($urandom_range(0, 5));
            pulse_a(pg, t);
            wait_done_a(1, 1000, "rand_timeout");
            repeat (2) @(posedge clk); #1;
            check("rand_oam",      32'(oam_errs(1'b0, pg, 160)), 32'd0);
            check("rand_done_cyc", 32'(done_cyc_a - t), 32'd645);
        end

        // Mid-transfer write
        clr_a();
        t = cyc + 1;
        pulse_a(8'h80, t);
        pulse_a(8'hC0, t + 100);
        wait_done_a(1, 1500, "mid_timeout");
        repeat (50) @(posedge clk); #1;
        check("mid_done_cnt", 32'(done_cnt_a), 32'd1);
        check("mid_busy_falls", 32'(falls_a),  32'd1);
        check("mid_reg_rd",   32'(a_rd),       32'hC0);
`ifdef OAM_DMA_RESTART_EN
        check("mid_oam",      32'(oam_errs(1'b0, 8'hC0, 160)), 32'd0);
        check("mid_done_cyc", 32'(done_cyc_a - t), 32'd745);
        check("mid_busy_len", 32'(busy_cnt_a),     32'd744);
`else
        check("mid_oam",      32'(oam_errs(1'b0, 8'h80, 160)), 32'd0);
        check("mid_done_cyc", 32'(done_cyc_a - t), 32'd645);
        check("mid_busy_len", 32'(busy_cnt_a),     32'd644);
`endif

        // Reset abort at cycle 50 (an OAM write cycle)
        clr_a();
        t = cyc + 1;
        pulse_a(8'hC0, t);
        goto_cyc(t + 50);
        check("abort_we_before", 32'(a_oe), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_we",   32'(a_oe),   32'd0);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_re",   32'(a_re),   32'd0);
        check("abort_rd",   32'(a_rd),   32'hFF);
        n = we_cnt_a;
        repeat (3) @(posedge clk); #1;
        check("abort_no_we", 32'(we_cnt_a - n), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        clr_a();
        t = cyc + 1;
        pulse_a(8'hC0, t);
        wait_done_a(1, 1000, "abort_timeout");
        repeat (2) @(posedge clk); #1;
        check("abort_oam",      32'(oam_errs(1'b0, 8'hC0, 160)), 32'd0);
        check("abort_done_cyc", 32'(done_cyc_a - t), 32'd645);

        // Back-to-back triggers on the small instance
        clr_b();
        p1 = 8'($urandom_range(0, 255));
        p2 = 8'($urandom_range(0, 255));
        t = cyc + 1;
        pulse_b(p1, t);
        goto_cyc(t + 9);
        check("b2b_done_at_9", 32'(b_done), 32'd1);
        pulse_b(p2, t + 9);
        n = 0;
        while (dq_b.size() < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_timeout", 32'(dq_b.size() >= 2), 32'd1);
        repeat (3) @(posedge clk); #1;
        if (dq_b.size() >= 2) begin
            check("b2b_done1", 32'(dq_b[0] - t), 32'd9);
            check("b2b_done2", 32'(dq_b[1] - t), 32'd18);
        end
        check("b2b_busy_len", 32'(busy_cnt_b), 32'd16);
        check("b2b_we_cnt",   32'(we_cnt_b),   32'd8);
        check("b2b_oam",      32'(oam_errs(1'b1, p2, 4)), 32'd0);
        check("b2b_reg_rd",   32'(b_rd),       32'(p2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
